decode_stage: RTL and testbench

Front-end decode pipeline stage sitting between instruction fetch and register read/execute. It accepts fetched instructions over a valid/ready handshake, splits out register and function fields, and generates the sign-extended immediate. It registers the results with a two-entry skid buffer, so fetch sees a registered `in_ready` and full throughput is kept under backpressure. It also sequences the stage: stall, flush on control-flow redirect, and post-reset start-up.

---
 rtl/decode_stage.sv | 148 ++++++++++++++
 tb/tb_decode_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with two-entry skid buffer
// Optional illegal-instruction flag: DECODE_ILLEGAL_CHECK_EN
module decode_stage #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [31:0]     out_imm,
  output logic [2:0]      out_fmt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7
`ifdef DECODE_ILLEGAL_CHECK_EN
  ,
  output logic            out_illegal
`endif
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_R    = 3'd1;
  localparam logic [2:0] FMT_I    = 3'd2;
  localparam logic [2:0] FMT_S    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_U    = 3'd5;
  localparam logic [2:0] FMT_J    = 3'd6;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [31:0]     imm;
    logic [2:0]      fmt;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic            illegal;
`endif
  } entry_t;

  entry_t m_q, m_d, k_q, k_d, dec;
  logic   m_valid_q, m_valid_d;
  logic   k_valid_q, k_valid_d;
  logic   started_q;
  logic   accept, drain;

  // Decode happens before the registers so every output is a flop.
  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.instr = in_instr;
    case (in_instr[6:0])
      7'b0110011:                                     dec.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec.fmt = FMT_I;
      7'b0100011:                                     dec.fmt = FMT_S;
      7'b1100011:                                     dec.fmt = FMT_B;
      7'b0110111, 7'b0010111:                         dec.fmt = FMT_U;
      7'b1101111:                                     dec.fmt = FMT_J;
      default:                                        dec.fmt = FMT_NONE;
    endcase
    case (dec.fmt)
      FMT_I:   dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   dec.imm = {in_instr[31:12], 12'b0};
      FMT_J:   dec.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      default: dec.imm = 32'd0;
    endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
    // Every mapped opcode ends in 2'b11, so a bad low pair already yields NONE.
    dec.illegal = (in_instr[1:0] != 2'b11) || (dec.fmt == FMT_NONE);
`endif
  end

  assign in_ready  = ~k_valid_q & started_q;
  assign out_valid = m_valid_q;
  assign accept    = in_valid & in_ready;
  assign drain     = m_valid_q & out_ready;

  // An accept implies K is empty, so K->M promotion and accept never collide.
  always_comb begin
    m_d       = m_q;
    k_d       = k_q;
    m_valid_d = m_valid_q;
    k_valid_d = k_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else begin
      if (drain) begin
        if (k_valid_q) begin
          m_d       = k_q;
          k_valid_d = 1'b0;
        end else begin
          m_valid_d = 1'b0;
        end
      end
      if (accept) begin
        if (!m_valid_q || (drain && !k_valid_q)) begin
          m_d       = dec;
          m_valid_d = 1'b1;
        end else begin
          k_d       = dec;
          k_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q       <= '0;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      k_q       <= k_d;
      m_valid_q <= m_valid_d;
      k_valid_q <= k_valid_d;
      started_q <= 1'b1;
    end
  end

  assign out_pc     = m_q.pc;
  assign out_instr  = m_q.instr;
  assign out_imm    = m_q.imm;
  assign out_fmt    = m_q.fmt;
  assign out_rd     = m_q.instr[11:7];
  assign out_rs1    = m_q.instr[19:15];
  assign out_rs2    = m_q.instr[24:20];
  assign out_funct3 = m_q.instr[14:12];
  assign out_funct7 = m_q.instr[31:25];
`ifdef DECODE_ILLEGAL_CHECK_EN
  assign out_illegal = m_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
// Honours DECODE_ILLEGAL_CHECK_EN for the out_illegal port.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
`ifdef DECODE_ILLEGAL_CHECK_EN
  logic        out_illegal;
`endif

  always #5 clk = ~clk;

  decode_stage #(.PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7)
`ifdef DECODE_ILLEGAL_CHECK_EN
    , .out_illegal(out_illegal)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   pop_cyc[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   base;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got instr 0x%08h expected none", out_instr);
      end else begin
        me = sb.pop_front();
        check("out_instr", out_instr, me.instr);
        check("out_pc", out_pc, me.pc);
        check("out_imm", out_imm, me.imm);
        check("out_fmt", {29'd0, out_fmt}, {29'd0, me.fmt});
        check("out_rd", {27'd0, out_rd}, {27'd0, me.instr[11:7]});
        check("out_rs1", {27'd0, out_rs1}, {27'd0, me.instr[19:15]});
        check("out_rs2", {27'd0, out_rs2}, {27'd0, me.instr[24:20]});
        check("out_funct3", {29'd0, out_funct3}, {29'd0, me.instr[14:12]});
        check("out_funct7", {25'd0, out_funct7}, {25'd0, me.instr[31:25]});
`ifdef DECODE_ILLEGAL_CHECK_EN
        check("out_illegal", {31'd0, out_illegal}, {31'd0, me.ill});
`endif
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
    int   t;
    exp_t e;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for instr 0x%08h", instr);
    end else begin
      e = '{instr, pc, imm, fmt, ill};
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_instr"}, out_instr, 32'd0);
    check({tag, "_out_pc"}, out_pc, 32'd0);
    check({tag, "_out_imm"}, out_imm, 32'd0);
    check({tag, "_out_fmt"}, {29'd0, out_fmt}, 32'd0);
    check({tag, "_out_rd"}, {27'd0, out_rd}, 32'd0);
    check({tag, "_out_funct7"}, {25'd0, out_funct7}, 32'd0);
`ifdef DECODE_ILLEGAL_CHECK_EN
    check({tag, "_out_illegal"}, {31'd0, out_illegal}, 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("startup_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;

    // Format coverage, back to back
    base = pop_cyc.size();
    send(32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd2, 1'b0);
    send(32'h0020A423, 32'h104, 32'h00000008, 3'd3, 1'b0);
    send(32'hFE000EE3, 32'h108, 32'hFFFFFFFC, 3'd4, 1'b0);
    send(32'h001000EF, 32'h10C, 32'h00000800, 3'd6, 1'b0);
    send(32'h123452B7, 32'h110, 32'h12345000, 3'd5, 1'b0);
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("burst_count", pop_cyc.size(), base + 5);
    if (pop_cyc.size() == base + 5)
      check("burst_spacing", pop_cyc[base+4] - pop_cyc[base], 32'd4);
    @(posedge clk); #1;
    send(32'h002081B3, 32'h200, 32'h00000000, 3'd1, 1'b0);
    send(32'h0000007F, 32'h204, 32'h00000000, 3'd0, 1'b1);
    send(32'h00000013, 32'h208, 32'h00000000, 3'd2, 1'b0);
    send(32'h00000000, 32'h20C, 32'h00000000, 3'd0, 1'b1);
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Backpressure: A in M, B in K, C held
    out_ready = 1'b0;
    send(32'h00500093, 32'h300, 32'h00000005, 3'd2, 1'b0);
    send(32'hABCDE0B7, 32'h304, 32'hABCDE000, 3'd5, 1'b0);
    in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h308;
    @(negedge clk);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_out_instr", out_instr, 32'h00500093);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_instr", out_instr, 32'h00500093);
    check("bp_hold_imm", out_imm, 32'h00000005);
    @(posedge clk); #1;
    out_ready = 1'b1;
    base = pop_cyc.size();
    send(32'h402081B3, 32'h308, 32'h00000000, 3'd1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("bp_drain_count", pop_cyc.size(), base + 3);
    if (pop_cyc.size() == base + 3)
      check("bp_drain_spacing", pop_cyc[base+2] - pop_cyc[base], 32'd2);
    @(posedge clk); #1;

    // Flush with M and K full
    out_ready = 1'b0;
    send(32'h00100113, 32'h400, 32'h00000001, 3'd2, 1'b0);
    send(32'h0041A023, 32'h404, 32'h00000000, 3'd3, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h06300093; in_pc = 32'h408;
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    // Flush with an accept that would otherwise land in K
    send(32'h7FF00093, 32'h500, 32'h000007FF, 3'd2, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h06300093; in_pc = 32'h504;
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush2_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush2_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h800000EF, 32'h600, 32'hFFF00000, 3'd6, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Reset mid-stream
    out_ready = 1'b0;
    send(32'h00000013, 32'h700, 32'h00000000, 3'd2, 1'b0);
    send(32'hFFFFF037, 32'h704, 32'hFFFFF000, 3'd5, 1'b0);
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h708;
    sb.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check_zero_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("restart_gap_in_ready", {31'd0, in_ready}, 32'd0);
    check("restart_gap_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("restart_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h0020A423, 32'h800, 32'h00000008, 3'd3, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    check("scoreboard_empty", sb.size(), 32'd0);
    check("total_outputs", pop_cyc.size(), 32'd14);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
